serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- Parametrised UART receiver: the RX half of the board serial link, successor to the fixed 8N1 path on the icestick top level.
- Adds configurable data width, parity, stop-bit count, a receive FIFO with a valid/ready output, and per-frame error flags.
- Sits between the rs232_rx pin and the command decoder.

Parameters:
- FREQ, 12000000: clock frequency in Hz.
- BAUD, 9600: bit rate in baud.
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- DEPTH, 4: FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  serial input, idle high, asynchronous to clk
- data  out  DATA_WIDTH  head-of-FIFO data word
- valid  out  1  FIFO non-empty; data is meaningful
- ready  in  1  consumer accepts the head word when valid&ready
- parity_err  out  1  parity flag of the head word
- frame_err  out  1  pulse: stop bit sampled low
- overrun  out  1  pulse: frame completed while FIFO full
- brk  out  1  break-detect pulse (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops set to 1.
- rxd passes through a 2-flop synchroniser. All decisions below use the synchronised value.
- DIV = FREQ/BAUD, integer division. HALF = DIV/2. The bit counter is $clog2(DIV) wide.
- FSM states and transitions:
  - IDLE: a falling edge on synchronised rxd loads the counter with HALF, then go to START.
  - START: at counter expiry, sample rxd. If 0, reload DIV and go to DATA. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: DATA_WIDTH samples, one every DIV cycles, shifted in LSB first. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: one sample. Odd parity: the XOR of data and parity bit must be 1. Even parity: it must be 0. On mismatch the word's parity bit is set.
  - STOP: STOP_BITS samples.
    - All samples 1: push {parity bit, data} to the FIFO, then go to IDLE.
    - Any sample 0: frame_err pulses 1 cycle, the word is discarded, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd=1, then go to IDLE. This prevents mid-low retriggering.
- Push happens in the cycle of the final stop sample.
  - FIFO full: word dropped, overrun pulses 1 cycle, FIFO contents unchanged.
- Pop happens when valid&ready. data and parity_err then present the next entry on the following cycle, or valid falls if the FIFO is empty.
- Simultaneous push and pop on a full FIFO: the pop is taken first, so the push succeeds and there is no overrun.
- FIFO pointers are $clog2(DEPTH)+1 bits wide and wrap naturally; full/empty are decided by the MSB comparison.
- Latency: valid rises exactly 1 cycle after the final stop sample, when the FIFO was empty.
- Reset asserted mid-frame: FSM returns to IDLE and the FIFO is flushed.

Optional Feature:
- Macro SERIAL_RX_BREAK_EN.
- Defined: a frame whose data, parity and stop samples are all 0 pulses brk for 1 cycle instead of frame_err. No FIFO push occurs. The FSM enters WAIT_IDLE.
- Undefined: brk is tied 0, and an all-zero frame is reported as frame_err.

Decomposition:
- Package serial_pkg holds:
  - typedef parity_t (enum NONE, ODD, EVEN), shared with the future serial_tx;
  - function div(freq, baud);
  - rx_state_t enum for the FSM.
- One sub-module, serial_fifo: synchronous FIFO parameterised on WIDTH and DEPTH. Reused by serial_tx.

Test Plan:
- FREQ=12e6, BAUD=9600 (DIV=1250), 8N1. Send 0xA5 -> valid rises 1 cycle after the stop mid-sample, data=0xA5, parity_err=0. ready=1 -> valid falls next cycle.
- PARITY=2 (even). Send 0x03 with parity bit 1 -> parity_err=1. Send 0x03 with parity bit 0 -> parity_err=0.
- Stop bit driven 0 on a 0x55 frame -> frame_err pulses once, valid stays 0, and the next 0x5A frame is received correctly.
- DEPTH=4, ready=0. Send 5 frames 0x01..0x05 -> overrun pulses on frame 5. Popping yields 0x01..0x04 only.
- rxd low pulse of 300 cycles -> no valid, no flags, FSM back in IDLE. Also: rst_n asserted mid-frame -> outputs 0 and FIFO empty.
- With SERIAL_RX_BREAK_EN: hold rxd low for 12 bit times -> brk pulses once, frame_err=0, no push. Without the macro, the same stimulus pulses frame_err.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the board serial link (RX now, TX later).
package serial_pkg;

  // Parity mode; the encoding matches the integer PARITY parameter.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head word is presented
// combinationally on rdata. A pop on a full FIFO frees room for a push
// in the same cycle.
module serial_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Accept pop first so a full FIFO can take a simultaneous push.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; empty/full come from the
  // pointers, so stale contents are never observed and the array can map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_rx.sv
// Parametrised UART receiver with receive FIFO and per-frame error flags.
// Optional build macro SERIAL_RX_BREAK_EN: an all-zero frame (data,
// parity and stop samples) pulses brk instead of frame_err.
module serial_rx
  import serial_pkg::*;
#(
  parameter int FREQ       = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  brk
);

  localparam int      DIV      = div(FREQ, BAUD);
  localparam int      HALF     = DIV / 2;
  localparam int      CW       = $clog2(DIV);
  localparam int      BW       = 4;
  localparam parity_t PAR_MODE = parity_t'(PARITY);
  // The counter counts down to zero, so a load of N-1 spans N cycles.
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic                  sync1_q, sync2_q, rxd_prev_q;
  logic                  rxd_s, fall;
  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  stop_bad_q, stop_bad_d;
  logic                  stop_one_q, stop_one_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  brk_q, brk_d;
  logic                  tick, stop_bad, stop_one, is_break, perr;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   push_word, head_word;

  assign rxd_s = sync2_q;
  assign fall  = rxd_prev_q && !rxd_s;
  assign tick  = (cnt_q == '0);

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rxd_prev_q <= sync2_q;
    end
  end

  // Next-state, sampling and push decision for the receive FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement leaves a variable unassigned (no latches).
    state_d     = state_q;
    cnt_d       = tick ? cnt_q : cnt_q - 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    stop_bad_d  = stop_bad_q;
    stop_one_d  = stop_one_q;
    frame_err_d = 1'b0;
    brk_d       = 1'b0;
    push        = 1'b0;
    stop_bad    = stop_bad_q | ~rxd_s;
    stop_one    = stop_one_q | rxd_s;
    unique case (PAR_MODE)
      ODD:     perr = ~(^shift_q ^ par_q);
      EVEN:    perr = ^shift_q ^ par_q;
      default: perr = 1'b0;
    endcase
    push_word   = {perr, shift_q};
`ifdef SERIAL_RX_BREAK_EN
    is_break    = (shift_q == '0) && !par_q && !stop_one;
`else
    is_break    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_d   = HALF_M1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxd_s) begin
            cnt_d      = DIV_M1;
            bit_d      = '0;
            par_d      = 1'b0;
            stop_bad_d = 1'b0;
            stop_one_d = 1'b0;
            state_d    = ST_DATA;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = DIV_M1;
          shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PAR_MODE == NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_d   = DIV_M1;
          par_d   = rxd_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d = DIV_M1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            if (!stop_bad) begin
              push        = 1'b1;
              state_d     = ST_IDLE;
            end else if (is_break) begin
              brk_d       = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            bit_d      = bit_q + 1'b1;
            stop_bad_d = stop_bad;
            stop_one_d = stop_one;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d = push && fifo_full && !pop;
  end

  // FSM, datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      stop_bad_q  <= 1'b0;
      stop_one_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      stop_bad_q  <= stop_bad_d;
      stop_one_q  <= stop_one_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      brk_q       <= brk_d;
    end
  end

  assign pop = valid && ready;

  serial_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head word is masked while empty so outputs read 0 out of reset.
  assign valid      = !fifo_empty;
  assign data       = valid ? head_word[DATA_WIDTH-1:0] : '0;
  assign parity_err = valid && head_word[DATA_WIDTH];
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign brk        = brk_q;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: 8 data bits, even parity, 1 stop bit,
// DIV = 16 cycles per bit, FIFO depth 4.
module tb_serial_rx;

  localparam int FREQ  = 1_600_000;
  localparam int BAUD  = 100_000;
  localparam int DIV   = FREQ / BAUD;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       brk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0, ovr_cnt = 0, brk_cnt = 0;
  logic valid_prev = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  serial_rx #(
    .FREQ       (FREQ),
    .BAUD       (BAUD),
    .DATA_WIDTH (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .brk        (brk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: counts flag pulses, logs popped words and valid rise times.
  always @(negedge clk) begin
    valid_prev <= valid;
    if (valid && !valid_prev) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ovr_cnt <= ovr_cnt + 1;
    if (brk)       brk_cnt <= brk_cnt + 1;
    if (valid && ready) got_q.push_back({parity_err, data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Even-parity bit that makes the frame correct.
  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  // Serial frame: start, 8 data bits LSB first, parity, stop; then idle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_v, input int gap);
    logic [10:0] bits;
    bits = {stop_v, p, d, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int b = 0; b < 11; b++) begin
      rxd = bits[b];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ovr0, brk0, lat, exp_fe, exp_brk;
    logic [7:0] d;
    logic p, bad, st;

    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_flags", {parity_err, frame_err, overrun, brk}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame, latency from stop mid-sample, then pop.
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 2 * DIV);
    lat = rise_cyc - start_cyc;
    check("a5_latency_window", (lat >= 10 * DIV + DIV / 2) && (lat <= 10 * DIV + DIV / 2 + 5), 1);
    check("a5_valid", valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_perr", parity_err, 0);
    pop_one();
    check("a5_valid_after_pop", valid, 0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong.
    send_frame(8'h03, 1'b1, 1'b1, 2 * DIV);
    check("par_bad_data", data, 8'h03);
    check("par_bad_flag", parity_err, 1);
    pop_one();
    send_frame(8'h03, 1'b0, 1'b1, 2 * DIV);
    check("par_good_data", data, 8'h03);
    check("par_good_flag", parity_err, 0);
    pop_one();

    // Stop bit low: frame error, no push, next frame still fine.
    fe0 = fe_cnt;
    send_frame(8'h55, good_par(8'h55), 1'b0, 2 * DIV);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_no_push", valid, 0);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 2 * DIV);
    check("after_fe_valid", valid, 1);
    check("after_fe_data", {parity_err, data}, {1'b0, 8'h5A});
    pop_one();

    // Overrun: five frames into a four-entry FIFO with no consumer.
    ovr0 = ovr_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), good_par(8'(k)), 1'b1, 2 * DIV);
      if (k == 4) check("ovr_none_at_4", ovr_cnt - ovr0, 0);
    end
    check("ovr_pulse_at_5", ovr_cnt - ovr0, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      check($sformatf("ovr_pop_%0d", k), {valid, data}, {1'b1, 8'(k)});
      pop_one();
    end
    check("ovr_empty", valid, 0);

    // Short low glitch: no word, no flags, receiver still usable.
    fe0 = fe_cnt; ovr0 = ovr_cnt; brk0 = brk_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("glitch_no_valid", valid, 0);
    check("glitch_no_flags", (fe_cnt - fe0) + (ovr_cnt - ovr0) + (brk_cnt - brk0), 0);
    send_frame(8'hC3, good_par(8'hC3), 1'b1, 2 * DIV);
    check("glitch_then_rx", {valid, data}, {1'b1, 8'hC3});

    // Reset mid-frame with a word still queued: FIFO flushed.
    @(negedge clk);
    rxd = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_outs", {data, parity_err, frame_err, overrun, brk}, 0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("rst_mid_still_empty", valid, 0);
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 2 * DIV);
    check("rst_mid_then_rx", {valid, parity_err, data}, {2'b10, 8'h3C});
    pop_one();

    // Line held low for 12 bit times.
    fe0 = fe_cnt; brk0 = brk_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
`ifdef SERIAL_RX_BREAK_EN
    check("break_brk", brk_cnt - brk0, 1);
    check("break_fe", fe_cnt - fe0, 0);
`else
    check("break_brk", brk_cnt - brk0, 0);
    check("break_fe", fe_cnt - fe0, 1);
`endif
    check("break_no_push", valid, 0);

    // Randomised frames against the reference model, consumer always ready.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ovr0 = ovr_cnt; brk0 = brk_cnt;
    exp_fe = 0; exp_brk = 0;
    ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      if (i == 5) d = 8'h00;
      bad = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) != 0);
      p   = good_par(d) ^ bad;
      if (st) begin
        exp_q.push_back({(($countones(d) + int'(p)) % 2) != 0, d});
      end else begin
`ifdef SERIAL_RX_BREAK_EN
        if (d == 8'h00 && !p) exp_brk++;
        else exp_fe++;
`else
        exp_fe++;
`endif
      end
      send_frame(d, p, st, 2 + $urandom_range(0, 2 * DIV));
    end
    repeat (2 * DIV) @(negedge clk);
    ready = 1'b0;
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_word_%0d", i), got_q[i], exp_q[i]);
    check("rand_frame_err", fe_cnt - fe0, exp_fe);
    check("rand_brk", brk_cnt - brk0, exp_brk);
    check("rand_overrun", ovr_cnt - ovr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
